// File: rtl/bp_reg_bank.sv
// BytePipe register bank: decodes a byte command stream into
// burst/ctrl registers, packet-FIFO read ports, RO and RW bytes.
module bp_reg_bank #(
  parameter int N_FIFO = 1,
  parameter int N_RO = 4,
  parameter int N_RW = 4,
  parameter logic [N_RW*8-1:0] RW_RESET = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cg,
  input  logic [N_FIFO*8-1:0] i_pktfifo_data,
  input  logic [N_FIFO-1:0] i_pktfifo_empty,
  output logic [N_FIFO-1:0] o_pktfifo_pop,
  output logic [N_FIFO-1:0] o_pktfifo_flush,
  input  logic [N_RO*8-1:0] i_ro,
  output logic [N_RW*8-1:0] o_rw,
  output logic [N_RW-1:0]   o_rwWrite,
  input  logic [7:0]        i_bp_data,
  input  logic              i_bp_valid,
  output logic              o_bp_ready,
  output logic [7:0]        o_bp_data,
  output logic              o_bp_valid,
  input  logic              i_bp_ready
);

  localparam int FB = 2;
  localparam int RB = FB + N_FIFO;
  localparam int WB = RB + N_RO;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD
  } state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] burst_q, burst_d;
  logic autoinc_q, autoinc_d;
  logic echo_q, echo_d;
  logic [N_RW*8-1:0] rw_q, rw_d;
  logic [7:0] dout_q, dout_d;
  logic vld_q, vld_d;

  logic [7:0] rd_val;
  logic rd_ok;
  logic [N_FIFO-1:0] pop_sel;
  logic [N_FIFO-1:0] pop;
  logic [N_FIFO-1:0] flush;
  logic [N_RW-1:0] rww;
  logic out_free;
  logic accept;
  logic [6:0] nxt_addr;
  logic [7:0] start_cnt;

  assign out_free = !vld_q || i_bp_ready;
  assign o_bp_ready = i_cg && (state_q != S_RD) && out_free;
  assign accept = o_bp_ready && i_bp_valid;
  assign start_cnt = (burst_q == 8'd0) ? 8'd1 : burst_q;

  // Next address: wrap 127 -> 1 so auto-increment never hits BURST.
  always_comb begin
    nxt_addr = addr_q;
    if (autoinc_q) begin
      if (addr_q == 7'd127) nxt_addr = 7'd1;
      else nxt_addr = addr_q + 7'd1;
    end
  end

  // Read mux for the current address; FIFO reads stall when empty.
  always_comb begin
    rd_val = 8'h00;
    rd_ok = 1'b1;
    pop_sel = '0;
    if (addr_q == 7'd0) rd_val = burst_q;
    if (addr_q == 7'd1) rd_val = {7'd0, autoinc_q};
    for (int i = 0; i < N_FIFO; i++) begin
      if (addr_q == 7'(FB + i) && !echo_q) begin
        rd_val = i_pktfifo_data[8*i +: 8];
        rd_ok = !i_pktfifo_empty[i];
        pop_sel[i] = 1'b1;
      end
    end
    for (int k = 0; k < N_RO; k++) begin
      if (addr_q == 7'(RB + k)) rd_val = i_ro[8*k +: 8];
    end
    for (int k = 0; k < N_RW; k++) begin
      if (addr_q == 7'(WB + k)) rd_val = rw_q[8*k +: 8];
    end
  end

  // Command FSM: next state, register writes and strobes.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    burst_d = burst_q;
    autoinc_d = autoinc_q;
    echo_d = echo_q;
    rw_d = rw_q;
    dout_d = dout_q;
    vld_d = vld_q;
    pop = '0;
    flush = '0;
    rww = '0;
    if (i_cg) begin
      if (vld_q && i_bp_ready) vld_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_d = i_bp_data[6:0];
            cnt_d = start_cnt;
            echo_d = 1'b0;
            state_d = i_bp_data[7] ? S_WR : S_RD;
            if (i_bp_data[6:0] != 7'd0) burst_d = 8'd0;
          end
        end
        S_WR: begin
          if (accept) begin
            if (addr_q == 7'd0) burst_d = i_bp_data;
            if (addr_q == 7'd1) autoinc_d = i_bp_data[0];
            for (int i = 0; i < N_FIFO; i++) begin
              if (addr_q == 7'(FB + i)) flush[i] = 1'b1;
            end
            for (int k = 0; k < N_RW; k++) begin
              if (addr_q == 7'(WB + k)) begin
                rw_d[8*k +: 8] = i_bp_data;
                rww[k] = 1'b1;
              end
            end
            if (cnt_q == 8'd1) begin
              state_d = S_RD;
              cnt_d = 8'd1;
              echo_d = 1'b1;
            end else begin
              cnt_d = cnt_q - 8'd1;
              addr_d = nxt_addr;
            end
          end
        end
        S_RD: begin
          if (out_free && rd_ok) begin
            vld_d = 1'b1;
            dout_d = rd_val;
            pop = pop_sel;
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_d = S_IDLE;
              echo_d = 1'b0;
            end else begin
              addr_d = nxt_addr;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q <= 8'd0;
      addr_q <= 7'd0;
      burst_q <= 8'd0;
      autoinc_q <= 1'b0;
      echo_q <= 1'b0;
      rw_q <= RW_RESET;
      dout_q <= 8'h00;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      burst_q <= burst_d;
      autoinc_q <= autoinc_d;
      echo_q <= echo_d;
      rw_q <= rw_d;
      dout_q <= dout_d;
      vld_q <= vld_d;
    end
  end

  assign o_pktfifo_pop = pop;
  assign o_pktfifo_flush = flush;
  assign o_rwWrite = rww;
  assign o_rw = rw_q;
  assign o_bp_data = dout_q;
  assign o_bp_valid = vld_q;

endmodule

// File: doc/bp_reg_bank.md
# bp_reg_bank

Parametrised BytePipe register bank for USB-attached designs. It decodes a byte-stream command protocol into a configurable set of registers: N_FIFO packet-FIFO read ports, N_RO read-only bytes and N_RW read/write bytes. It adds counted burst transfers and optional address auto-increment. It sits between the USB BytePipe endpoint and the datapath, generalising the fixed single-FIFO register map of earlier designs.

## Interface
- N_FIFO, 1: packet-FIFO read ports, 1..8.
- N_RO, 4: read-only bytes, 0..64.
- N_RW, 4: read/write bytes, 1..64.
- RW_RESET, 0: N_RW*8-bit flat reset values; byte k is bits [8k+7:8k].
- Constraint: 2+N_FIFO+N_RO+N_RW <= 128.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_cg  in  1  clock-gate enable. Low: all state holds; pop, flush and write strobes are forced low.
- i_pktfifo_data  in  N_FIFO*8  head byte of each FIFO.
- i_pktfifo_empty  in  N_FIFO  per-FIFO empty flag.
- o_pktfifo_pop  out  N_FIFO  one-cycle pop pulse.
- o_pktfifo_flush  out  N_FIFO  one-cycle flush pulse.
- i_ro  in  N_RO*8  read-only values.
- o_rw  out  N_RW*8  RW register contents.
- o_rwWrite  out  N_RW  one-cycle pulse in the cycle a byte is written.
- i_bp_data/i_bp_valid/o_bp_ready  in/in/out  8/1/1  inbound BytePipe.
- o_bp_data/o_bp_valid/i_bp_ready  out/out/in  8/1/1  outbound BytePipe.

## Operation
- Command byte: bit7 = 1 for write, 0 for read; bits [6:0] = address A.
- Address map:
  - 0: BURST, holds B.
  - 1: CTRL; bit0 = AUTOINC, bits [7:1] read 0.
  - 2..: FIFO i.
  - Then RO k.
  - Then RW k.
  - Other addresses read 0x00 and ignore writes.
- FSM states: IDLE, WR, RD, with remaining count R (8b).
- IDLE: an accepted command loads the address register.
  - Write command: go to WR with R = max(B,1).
  - Read command: go to RD with R = max(B,1).
  - If A != 0, B clears to 0 (burst consumed).
- WR: each accepted byte writes the current address and decrements R.
  - When R reaches 0, go to RD with R = 1 (single echo byte).
  - Write effects by address:
    - BURST: sets B.
    - CTRL: sets AUTOINC.
    - FIFO i: pulses o_pktfifo_flush[i].
    - RW k: updates the byte and pulses o_rwWrite[k].
    - RO and unmapped: no effect.
- RD: when the output register is free (!o_bp_valid || i_bp_ready), load the read value of the current address and decrement R.
  - When R reaches 0, go to IDLE.
  - A FIFO read loads only if that FIFO is non-empty, pulsing o_pktfifo_pop[i] in the load cycle; otherwise it stalls.
  - The echo after a write returns the post-write value; a FIFO address echoes 0x00.
- AUTOINC=1: the address increments after each burst byte (write accept or read load), wrapping 127 -> 1 and never landing on 0. AUTOINC=0: the address is fixed.
- o_bp_ready = i_cg && (IDLE || WR) && (!o_bp_valid || i_bp_ready).
- Reset values:
  - State IDLE, B=0, AUTOINC=0, o_rw=RW_RESET.
  - o_bp_valid=0, o_bp_data=0x00.
  - All pulses 0.
- Reset mid-transaction: return to IDLE on that edge and drop any pending byte.

## Timing
- Read command accepted at cycle T: response valid at T+2 (FIFO non-empty, output free).
- Last write data byte accepted at T: o_rw updates at T+1, o_rwWrite pulses at T, echo is valid at T+2.
- Burst read with i_bp_ready held high: one byte per cycle, back-to-back.
- o_bp_data is stable while o_bp_valid && !i_bp_ready.
- An empty FIFO mid-burst: o_bp_valid drops and the burst resumes on the next non-empty cycle; R is unchanged while stalled.
- Pulses never occur when i_cg = 0.
- Simultaneous write to BURST and burst in progress: impossible, because the BURST write itself sets B.

## Test plan
- After reset, read RW0 with RW_RESET byte0 = 0x5A -> one response 0x5A at T+2; o_bp_ready high again from T+3.
- Write 0x81 0x07 (CTRL=1); write 0x80 0x03 (B=3); write RW0 base + 0x11 0x22 0x33 -> three o_rwWrite pulses on RW0..RW2, one echo 0x33, B reads back 0.
- B=4 with AUTOINC=0, read FIFO0 holding 2 bytes -> 2 bytes out, valid low, push 2 more -> 2 more bytes out, 4 pops total.
- Burst read of 5 RO bytes with i_bp_ready toggling every cycle -> data held stable, exactly 5 accepted bytes in order.
- Write FIFO1 address (0x83, any data) -> o_pktfifo_flush[1] pulses once, echo 0x00; write to address 0x7F -> no effects, echo 0x00.
- Assert i_rst mid-burst-read (R=3) -> o_bp_valid 0 next cycle, IDLE, B=0, o_rw=RW_RESET; hold i_cg=0 -> no pulses, no state change.
